// File: rtl/fir_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fir_ctrl_pkg
// Shared definitions for the 5x5 FIR coefficient control path: kernel
// geometry, the default coefficient width, the scheduler state encoding and
// a helper that flattens a (row, col) tap position into a linear tap index.
// ---------------------------------------------------------------------------
package fir_ctrl_pkg;

    localparam int KERNEL_TAPS     = 25;
    localparam int KERNEL_DIM      = 5;
    localparam int CENTER_TAP      = 12;
    localparam int DEFAULT_COEFF_W = 16;
    localparam int TAP_ADDR_W      = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } ctrl_state_t;

    // Linear tap index k = row*KERNEL_DIM + col, as used on the write port
    // and in the flattened coefficient bus.
    function automatic logic [TAP_ADDR_W-1:0] tap_index(input int unsigned row,
                                                        input int unsigned col);
        int unsigned k;
        k = row * KERNEL_DIM + col;
        return k[TAP_ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/vs_edge_detect.sv
// ---------------------------------------------------------------------------
// vs_edge_detect
// Registers the vertical sync every cycle and flags the cycle in which vs
// enters its active level (frame start).
//
// Parameters:
//   VS_POL       active level of vs; frame start is the transition into it
// Ports:
//   clk          pixel clock
//   rst          synchronous active-high reset (vs_q forced inactive)
//   vs           vertical sync input
//   frame_start  high in the cycle vs is active while vs_q was inactive
// ---------------------------------------------------------------------------
module vs_edge_detect #(
    parameter logic VS_POL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic vs,
    output logic frame_start
);

    logic vs_q;

    // NOTE: sequential state is always assigned with <= so every register
    // samples the pre-edge value of its inputs, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_q <= ~VS_POL;
        end else begin
            vs_q <= vs;
        end
    end

    // Resetting vs_q to the inactive level means a vs already active when
    // reset is released still counts as a frame start.
    assign frame_start = (vs == VS_POL) && (vs_q != VS_POL);

endmodule

// File: rtl/fir_coeff_scheduler.sv
// ---------------------------------------------------------------------------
// fir_coeff_scheduler
// Frame-synchronous coefficient controller for the 5x5 2D FIR. Host writes
// land in a shadow kernel bank; a commit arms a swap, and the next frame
// start copies shadow into the active bank that drives the filter, so the
// filter never sees a kernel change mid-frame.
//
// Optional feature macro: FIR_FRAME_CNT_EN
//   defined   -> 16-bit wrapping frame counter exposed on frame_cnt_o
//   undefined -> counter and frame_cnt_o port absent
//
// Parameters:
//   COEFF_W       signed coefficient width
//   RESET_CENTER  reset value of the centre tap (identity kernel)
//   VS_POL        active level of vs_i
// Ports:
//   clk           pixel clock
//   rst           synchronous active-high reset
//   vs_i          vertical sync
//   wr_valid      coefficient write request
//   wr_ready      write accepted when wr_valid & wr_ready (IDLE only)
//   wr_addr       tap index 0..24; larger values are dropped and flagged
//   wr_data       signed coefficient value
//   commit_i      request to apply the shadow bank at the next frame start
//   busy_o        high while a swap is armed
//   swap_o        one-cycle pulse in the first cycle of the new kernel
//   addr_err_o    one-cycle pulse after an accepted out-of-range write
//   coeff_o       active kernel, tap k at [COEFF_W*k +: COEFF_W]
//   frame_cnt_o   frames seen (FIR_FRAME_CNT_EN only)
// ---------------------------------------------------------------------------
module fir_coeff_scheduler
    import fir_ctrl_pkg::*;
#(
    parameter int                          COEFF_W      = DEFAULT_COEFF_W,
    parameter logic signed [COEFF_W-1:0]   RESET_CENTER = 16'sd256,
    parameter logic                        VS_POL       = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             vs_i,
    input  logic                             wr_valid,
    output logic                             wr_ready,
    input  logic [TAP_ADDR_W-1:0]            wr_addr,
    input  logic [COEFF_W-1:0]               wr_data,
    input  logic                             commit_i,
    output logic                             busy_o,
    output logic                             swap_o,
    output logic                             addr_err_o,
    output logic [KERNEL_TAPS*COEFF_W-1:0]   coeff_o
`ifdef FIR_FRAME_CNT_EN
    ,
    output logic [15:0]                      frame_cnt_o
`endif
);

    localparam logic [TAP_ADDR_W-1:0] LAST_TAP = TAP_ADDR_W'(KERNEL_TAPS - 1);

    ctrl_state_t                 state_q;
    ctrl_state_t                 state_d;
    logic                        frame_start;
    logic                        do_swap;
    logic                        wr_accept;
    logic                        addr_ok;
    logic                        swap_q;
    logic                        addr_err_q;
    logic signed [COEFF_W-1:0]   shadow_q [KERNEL_TAPS];
    logic signed [COEFF_W-1:0]   active_q [KERNEL_TAPS];

    // -----------------------------------------------------------------------
    // Frame-start detection
    // -----------------------------------------------------------------------
    vs_edge_detect #(
        .VS_POL (VS_POL)
    ) u_vs_edge (
        .clk         (clk),
        .rst         (rst),
        .vs          (vs_i),
        .frame_start (frame_start)
    );

    // -----------------------------------------------------------------------
    // Write handshake
    // -----------------------------------------------------------------------
    // Back-pressure while ARMED keeps the pending kernel from being torn.
    assign wr_ready  = (state_q == IDLE) && !rst;
    assign wr_accept = wr_valid && wr_ready;
    assign addr_ok   = (wr_addr <= LAST_TAP);

    // -----------------------------------------------------------------------
    // Scheduler FSM
    // -----------------------------------------------------------------------
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; that is what keeps this block from inferring latches.
    always_comb begin
        state_d = state_q;
        do_swap = 1'b0;
        unique case (state_q)
            IDLE: begin
                // A frame start in the arming cycle is deliberately ignored:
                // the swap waits for the next frame.
                if (commit_i) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                // commit_i is ignored here; only the frame edge matters.
                if (frame_start) begin
                    state_d = IDLE;
                    do_swap = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            swap_q     <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            swap_q     <= do_swap;
            addr_err_q <= wr_accept && !addr_ok;
        end
    end

    // -----------------------------------------------------------------------
    // Kernel banks
    // -----------------------------------------------------------------------
    // NOTE: both banks are small flop arrays, not RAM, and are reset on
    // purpose: the filter must run an identity kernel straight out of reset
    // and a reset mid-ARMED must discard whatever the host had staged.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < KERNEL_TAPS; k++) begin
                shadow_q[k] <= (k == CENTER_TAP) ? RESET_CENTER : '0;
                active_q[k] <= (k == CENTER_TAP) ? RESET_CENTER : '0;
            end
        end else begin
            // Writes happen only in IDLE and swaps only leave ARMED, so the
            // two never coincide; a write in the committing cycle still lands
            // before the swap that follows it.
            if (wr_accept && addr_ok) begin
                shadow_q[wr_addr] <= wr_data;
            end
            if (do_swap) begin
                active_q <= shadow_q;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign busy_o     = (state_q == ARMED);
    assign swap_o     = swap_q;
    assign addr_err_o = addr_err_q;

    for (genvar r = 0; r < KERNEL_DIM; r++) begin : g_row
        for (genvar c = 0; c < KERNEL_DIM; c++) begin : g_col
            localparam int K = int'(tap_index(r, c));
            assign coeff_o[COEFF_W*K +: COEFF_W] = active_q[K];
        end
    end

`ifdef FIR_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    // Counts every frame start regardless of state; wraps 0xFFFF -> 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else if (frame_start) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt_o = frame_cnt_q;
`endif

endmodule

// File: tb/tb_fir_coeff_scheduler.sv
// ---------------------------------------------------------------------------
// tb_fir_coeff_scheduler
// Directed scenarios followed by randomized traffic. A driver task applies
// one cycle of stimulus and updates a behavioural model (two tap arrays and
// an armed flag); expected swap kernels and address-error pulses are queued
// and consumed by an independent monitor when the DUT presents them.
// ---------------------------------------------------------------------------
module tb_fir_coeff_scheduler;
    import fir_ctrl_pkg::*;

    localparam int W  = 16;
    localparam int KW = 25 * W;
    typedef logic [KW-1:0] kernel_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          vs_i;
    logic          wr_valid;
    logic          wr_ready;
    logic [4:0]    wr_addr;
    logic [W-1:0]  wr_data;
    logic          commit_i;
    logic          busy_o;
    logic          swap_o;
    logic          addr_err_o;
    kernel_t       coeff_o;
`ifdef FIR_FRAME_CNT_EN
    logic [15:0]   frame_cnt_o;
`endif

    fir_coeff_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .vs_i       (vs_i),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .commit_i   (commit_i),
        .busy_o     (busy_o),
        .swap_o     (swap_o),
        .addr_err_o (addr_err_o),
        .coeff_o    (coeff_o)
`ifdef FIR_FRAME_CNT_EN
        ,
        .frame_cnt_o(frame_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [W-1:0] m_shadow [25];
    logic [W-1:0] m_active [25];
    bit           m_armed;
    bit           m_vs_prev;
    logic [15:0]  m_cnt;
    kernel_t      swap_exp_q [$];
    int           err_exp_q  [$];

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    task automatic check(input string name, input kernel_t act, input kernel_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic kernel_t pack_active();
        kernel_t v;
        for (int k = 0; k < 25; k++) v[W*k +: W] = m_active[k];
        return v;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 25; k++) begin
            m_shadow[k] = (k == 12) ? 16'h0100 : 16'h0000;
            m_active[k] = m_shadow[k];
        end
        m_armed   = 1'b0;
        m_vs_prev = 1'b0;
        m_cnt     = 16'h0000;
        swap_exp_q.delete();
        err_exp_q.delete();
    endfunction

    // One clock of stimulus plus the model's view of what it does.
    task automatic step(input logic vs, input logic wv, input logic [4:0] wa,
                        input logic [W-1:0] wd, input logic cm);
        bit frame_edge;
        @(negedge clk);
        rst = 1'b0; vs_i = vs; wr_valid = wv; wr_addr = wa; wr_data = wd; commit_i = cm;
        frame_edge = vs && !m_vs_prev;
        m_vs_prev  = vs;
        if (frame_edge) m_cnt = m_cnt + 16'd1;
        if (wv && !m_armed) begin
            if (wa <= 5'd24) m_shadow[wa] = wd;
            else             err_exp_q.push_back(1);
        end
        if (!m_armed) begin
            if (cm) m_armed = 1'b1;
        end else if (frame_edge) begin
            m_active = m_shadow;
            swap_exp_q.push_back(pack_active());
            m_armed = 1'b0;
        end
    endtask

    task automatic idle(input logic vs, input int n);
        for (int i = 0; i < n; i++) step(vs, 1'b0, 5'd0, '0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; vs_i = 1'b0; wr_valid = 1'b0; commit_i = 1'b0;
        model_reset();
    endtask

    task automatic write_all(input logic [W-1:0] val);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                step(1'b0, 1'b1, tap_index(r, c), val, 1'b0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        bit exp_bit;
        wait (mon_en);
        forever begin
            @(posedge clk);
            #1;
            exp_bit = (swap_exp_q.size() != 0);
            check("swap_o", kernel_t'(swap_o), kernel_t'(exp_bit));
            if (swap_o && exp_bit) check("swap_kernel", coeff_o, swap_exp_q.pop_front());
            else if (exp_bit)      void'(swap_exp_q.pop_front());
            exp_bit = (err_exp_q.size() != 0);
            check("addr_err_o", kernel_t'(addr_err_o), kernel_t'(exp_bit));
            if (exp_bit) void'(err_exp_q.pop_front());
            check("coeff_o", coeff_o, pack_active());
            check("busy_o", kernel_t'(busy_o), kernel_t'(m_armed));
            check("wr_ready", kernel_t'(wr_ready), kernel_t'(!m_armed && !rst));
`ifdef FIR_FRAME_CNT_EN
            check("frame_cnt_o", kernel_t'(frame_cnt_o), kernel_t'(m_cnt));
`endif
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic vs_r;
        rst = 1'b1; vs_i = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; commit_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        mon_en = 1'b1;

        // 1: write without commit leaves identity, no swap
        step(1'b0, 1'b1, 5'd0, 16'h0100, 1'b0);
        idle(1'b0, 3); idle(1'b1, 2); idle(1'b0, 2);

        // 2: full kernel of 0x0010, commit, frame edge some cycles later
        write_all(16'h0010);
        step(1'b0, 1'b0, 5'd0, '0, 1'b1);
        idle(1'b0, 8);
        idle(1'b1, 3);
        idle(1'b0, 2);

        // 3: commit in the same cycle as a vs rise -> swap on the next rise
        step(1'b0, 1'b1, 5'd3, 16'h1234, 1'b0);
        step(1'b1, 1'b0, 5'd0, '0, 1'b1);
        idle(1'b1, 3); idle(1'b0, 2); idle(1'b1, 2); idle(1'b0, 2);

        // 4: out-of-range write is dropped and flagged
        step(1'b0, 1'b1, 5'd27, 16'h7FFF, 1'b0);
        step(1'b0, 1'b0, 5'd0, '0, 1'b1);
        idle(1'b0, 2); idle(1'b1, 2); idle(1'b0, 2);

        // 5: reset while ARMED discards the staged kernel
        write_all(16'h0005);
        step(1'b0, 1'b0, 5'd0, '0, 1'b1);
        idle(1'b0, 3);
        do_reset();
        idle(1'b0, 2); idle(1'b1, 2); idle(1'b0, 2);

        // 6: same-cycle write and commit, with edge boundaries at 24/25
        step(1'b0, 1'b1, 5'd24, 16'h8001, 1'b1);
        idle(1'b0, 1); idle(1'b1, 1); idle(1'b0, 1);
        step(1'b0, 1'b1, 5'd25, 16'h4444, 1'b0);
        idle(1'b0, 2);

        // 7: randomized traffic
        vs_r = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
                vs_r = 1'b0;
            end else begin
                if ($urandom_range(0, 7) == 0) vs_r = ~vs_r;
                step(vs_r, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 27)),
                     16'($urandom), 1'($urandom_range(0, 9) == 0));
            end
        end

        idle(1'b0, 4);
        @(negedge clk);
        check("swap_queue_drained", kernel_t'(swap_exp_q.size()), '0);
        check("err_queue_drained", kernel_t'(err_exp_q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_coeff_scheduler.md
# fir_coeff_scheduler

Frame-synchronous coefficient controller for the 5x5 2D FIR datapath. It collects host coefficient writes into a shadow kernel bank. On a commit request it arms a swap, and at the next frame start (vsync rising edge) it copies the shadow bank into the active bank that drives the systolic filter. The filter therefore never sees a kernel that changes mid-frame. It sits between the AXI-to-coefficient bridge and the cascade systolic FIR, in the pixel (`clk`) domain.

## Interface
Clock is `clk`. Reset `rst` is synchronous and active-high.

Parameters:
- `COEFF_W`, 16: signed coefficient width.
- `RESET_CENTER`, 16'sd256: reset value of tap 12 (row 2, col 2). All other taps reset to 0, giving an identity kernel.
- `VS_POL`, 1: active level of `vs_i`. Frame start is the transition into this level.

Ports:
- `clk`, in, 1: pixel clock.
- `rst`, in, 1: synchronous active-high reset.
- `vs_i`, in, 1: vertical sync from the video input.
- `wr_valid`, in, 1: coefficient write request.
- `wr_ready`, out, 1: write accepted when `wr_valid & wr_ready`.
- `wr_addr`, in, 5: tap index k = row*5+col, legal range 0..24.
- `wr_data`, in, COEFF_W: signed coefficient value.
- `commit_i`, in, 1: one-cycle request to apply the shadow bank at the next frame start.
- `busy_o`, out, 1: high while a swap is armed.
- `swap_o`, out, 1: one-cycle pulse in the first cycle the new active kernel is visible.
- `addr_err_o`, out, 1: one-cycle pulse after an accepted write with `wr_addr` > 24.
- `coeff_o`, out, 25*COEFF_W: active kernel, tap k at bits [COEFF_W*k +: COEFF_W].
- `frame_cnt_o`, out, 16: frames seen. Present only with `FIR_FRAME_CNT_EN`.

## Operation
- Two 25-entry banks: `shadow` (host writes) and `active` (drives `coeff_o`).
- State machine:
  - IDLE -> ARMED: on `commit_i`.
  - ARMED -> IDLE: on a frame-start edge, copying shadow into active in the same transition.
- `wr_ready` = (state == IDLE) & ~`rst`. Writes are back-pressured while ARMED, so the pending kernel cannot be torn.
- Accepted write with `wr_addr` <= 24: `shadow[wr_addr]` <= `wr_data`.
- Accepted write with `wr_addr` > 24: data dropped, `addr_err_o` pulses.
- Write and `commit_i` in the same IDLE cycle: the write lands and the commit arms. The write is part of the committed kernel.
- `commit_i` while ARMED is ignored.
- Frame-start edge: `vs_i` == VS_POL and registered `vs_q` != VS_POL, with `vs_q` sampled every cycle.
  - In IDLE the edge has no effect on the banks.
  - An edge in the same cycle as the arming commit does not swap; the swap waits for the next frame.
- Reset, including mid-ARMED:
  - state = IDLE.
  - Both banks = identity (tap 12 = RESET_CENTER, others 0).
  - `vs_q` = ~VS_POL.
  - `busy_o` = 0, `swap_o` = 0, `addr_err_o` = 0, frame counter = 0.
- Arithmetic: none on data. The counter wraps 0xFFFF -> 0x0000.

## Timing
- Write accepted in cycle n: `shadow` updated at the edge ending n. `addr_err_o` is high in cycle n+1 only.
- Commit in cycle n (IDLE): `busy_o` = 1 from cycle n+1 and `wr_ready` = 0 from cycle n+1.
- Frame-start edge detected in cycle m while ARMED:
  - `coeff_o` shows the new kernel from cycle m+1.
  - `swap_o` = 1 in cycle m+1 only.
  - `busy_o` = 0 and `wr_ready` = 1 from cycle m+1.
- `coeff_o` is registered and changes only on a swap or reset.
- Throughput: one write per cycle in IDLE.

## Configuration
- `FIR_FRAME_CNT_EN` defined: a 16-bit counter increments on every frame-start edge in any state and is exposed on `frame_cnt_o`. Reset value is 0.
- `FIR_FRAME_CNT_EN` undefined: the counter and the `frame_cnt_o` port are absent. All other behaviour is identical.

## Structure
- Shared package `fir_ctrl_pkg`:
  - Constants `KERNEL_TAPS` = 25, `KERNEL_DIM` = 5, `CENTER_TAP` = 12.
  - Default `COEFF_W`.
  - State enum {IDLE, ARMED}.
  - Flattened-kernel index helper function.
- One sub-module, `vs_edge_detect`: holds the registered `vs_q`, is parameterised by VS_POL, and outputs a frame-start pulse.

## Test plan
- Reset, then write tap 0 = 16'sh0100 with no commit:
  - `coeff_o` stays identity (tap 12 = 0x0100, others 0).
  - `swap_o` never pulses.
- Write all 25 taps = 16'sh0010, commit, then raise `vs_i` at cycle 40:
  - `busy_o` goes high one cycle after the commit.
  - `wr_ready` is low from that cycle.
  - At cycle 41 every tap = 0x0010 and `swap_o` = 1 for that one cycle.
- Commit issued in the same cycle as a `vs_i` rise:
  - No swap on that edge.
  - The swap occurs on the next `vs_i` rise.
- Write with `wr_addr` = 27, data 0x7FFF:
  - `addr_err_o` pulses once.
  - Shadow bank unchanged; verify by a commit plus frame edge showing the prior kernel.
- Assert `rst` while ARMED with the shadow bank = all 0x0005:
  - After reset: `busy_o` = 0, `wr_ready` = 1.
  - A following frame edge leaves `coeff_o` = identity.
- With `FIR_FRAME_CNT_EN`: preload the counter to 0xFFFE by applying 65534 frame edges, then apply 3 more edges: `frame_cnt_o` reads 0x0001.
